tsu_q_drain: RTL and testbench



---
 rtl/tsu_q_drain.sv | 191 +++++++++++++++++++
 tb/tb_tsu_q_drain.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tsu_q_drain.sv
// PTP timestamp-unit queue drain engine: a register-bus initiator that pops queue
// entries and presents each one as a valid/ready record.
module tsu_q_drain #(
  parameter logic [7:0]  CTRL_ADDR = 8'h40,
  parameter logic [7:0]  STAT_ADDR = 8'h44,
  parameter logic [7:0]  DATA_ADDR = 8'h50,
  parameter logic [7:0]  TS_ADDR   = 8'h80,
  parameter int unsigned POLL_MAX  = 16,
  parameter int unsigned IDLE_GAP  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [7:0]   msgid_mask,
  input  logic         mask_ld,
  input  logic         q_flush,
  output logic         bus_wr_out,
  output logic         bus_rd_out,
  output logic [7:0]   bus_addr_out,
  output logic [31:0]  bus_data_out,
  input  logic [31:0]  bus_data_in,
  output logic         rec_valid,
  input  logic         rec_ready,
  output logic [127:0] rec_data,
  output logic [79:0]  rec_ts,
  output logic [7:0]   rec_level,
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr
);

  localparam int unsigned GW = $clog2(IDLE_GAP + 1);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(IDLE_GAP);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FLUSH_HI, S_FLUSH_LO, S_CFG,
    S_STAT_RD, S_STAT_CAP, S_REQ_LO, S_REQ_HI,
    S_POLL_RD, S_POLL_CAP, S_ABORT,
    S_FETCH_RD, S_FETCH_CAP, S_PRESENT, S_REL
  } state_t;

  state_t         state, state_n;
  logic           flush_pending, mask_pending;
  logic [GW-1:0]  gap_cnt;
  logic [PW-1:0]  poll_cnt;
  logic [2:0]     fetch_idx;
  logic [7:0]     addr_q, op_addr, fetch_addr;
  logic [31:0]    data_q, op_data;
  logic           wr, rd;
  logic           stat_empty, poll_ok, poll_timeout, gap_expired;

  assign stat_empty   = (bus_data_in[7:0] == 8'h00);
  assign poll_ok      = bus_data_in[0];
  assign poll_timeout = (state == S_POLL_CAP) && !poll_ok && (poll_cnt == POLL_LAST);
  // Launch when the counter will have run out by the next edge, giving exactly
  // IDLE_GAP idle cycles between an empty status capture and the next poll.
  assign gap_expired  = (gap_cnt <= GW'(1));
  assign fetch_addr   = (fetch_idx[2] ? TS_ADDR : DATA_ADDR) + {4'b0000, fetch_idx[1:0], 2'b00};

  assign bus_wr_out   = wr;
  assign bus_rd_out   = rd;
  assign bus_addr_out = op_addr;
  assign bus_data_out = op_data;
  assign rec_valid    = (state == S_PRESENT);
  assign busy         = (state != S_IDLE);

  // Next state and bus operation; address/data hold their last value between strobes.
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    rd      = 1'b0;
    op_addr = addr_q;
    op_data = data_q;
    unique case (state)
      S_IDLE: begin
        if (flush_pending)              state_n = S_FLUSH_HI;
        else if (mask_pending)          state_n = S_CFG;
        else if (enable && gap_expired) state_n = S_STAT_RD;
      end
      S_FLUSH_HI: begin
        wr = 1'b1; op_addr = CTRL_ADDR; op_data = 32'h0000_0002;
        state_n = S_FLUSH_LO;
      end
      S_FLUSH_LO: begin
        wr = 1'b1; op_addr = CTRL_ADDR; op_data = '0;
        state_n = S_IDLE;
      end
      S_CFG: begin
        wr = 1'b1; op_addr = STAT_ADDR; op_data = {msgid_mask, 24'h000000};
        state_n = S_IDLE;
      end
      S_STAT_RD: begin
        rd = 1'b1; op_addr = STAT_ADDR;
        state_n = S_STAT_CAP;
      end
      S_STAT_CAP: state_n = stat_empty ? S_IDLE : S_REQ_LO;
      S_REQ_LO: begin
        wr = 1'b1; op_addr = CTRL_ADDR; op_data = '0;
        state_n = S_REQ_HI;
      end
      S_REQ_HI: begin
        wr = 1'b1; op_addr = CTRL_ADDR; op_data = 32'h0000_0001;
        state_n = S_POLL_RD;
      end
      S_POLL_RD: begin
        rd = 1'b1; op_addr = CTRL_ADDR;
        state_n = S_POLL_CAP;
      end
      S_POLL_CAP: begin
        if (poll_ok)           state_n = S_FETCH_RD;
        else if (poll_timeout) state_n = S_ABORT;
        else                   state_n = S_POLL_RD;
      end
      S_ABORT: begin
        wr = 1'b1; op_addr = CTRL_ADDR; op_data = '0;
        state_n = S_IDLE;
      end
      S_FETCH_RD: begin
        rd = 1'b1; op_addr = fetch_addr;
        state_n = S_FETCH_CAP;
      end
      S_FETCH_CAP: state_n = (fetch_idx == 3'd6) ? S_PRESENT : S_FETCH_RD;
      S_PRESENT:   if (rec_ready) state_n = S_REL;
      S_REL: begin
        wr = 1'b1; op_addr = CTRL_ADDR; op_data = '0;
        // Pending maintenance is only serviced from IDLE, so detour there first.
        state_n = (enable && !flush_pending && !mask_pending) ? S_STAT_RD : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, pending flags, counters and record capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      flush_pending <= 1'b0;
      mask_pending  <= 1'b1;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      fetch_idx     <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      timeout_err   <= 1'b0;
      rec_data      <= '0;
      rec_ts        <= '0;
      rec_level     <= '0;
    end else begin
      state         <= state_n;
      addr_q        <= op_addr;
      data_q        <= op_data;
      flush_pending <= q_flush || (flush_pending && (state != S_FLUSH_HI));
      mask_pending  <= mask_ld || (mask_pending && (state != S_CFG));
      timeout_err   <= poll_timeout || (timeout_err && !err_clr);

      if (((state == S_STAT_CAP) && stat_empty) || poll_timeout)
        gap_cnt <= GAP_LOAD;
      else if ((state == S_IDLE) && enable && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GW'(1);

      if ((state == S_STAT_CAP) && !stat_empty)
        rec_level <= bus_data_in[7:0];

      if (state == S_REQ_HI)
        poll_cnt <= '0;
      else if ((state == S_POLL_CAP) && !poll_ok)
        poll_cnt <= poll_cnt + PW'(1);

      if (state == S_POLL_CAP)
        fetch_idx <= '0;
      else if (state == S_FETCH_CAP)
        fetch_idx <= fetch_idx + 3'd1;

      if (state == S_FETCH_CAP) begin
        case (fetch_idx)
          3'd0: rec_data[127:96] <= bus_data_in;
          3'd1: rec_data[95:64]  <= bus_data_in;
          3'd2: rec_data[63:32]  <= bus_data_in;
          3'd3: rec_data[31:0]   <= bus_data_in;
          3'd4: rec_ts[79:64]    <= bus_data_in[15:0];
          3'd5: rec_ts[63:32]    <= bus_data_in;
          3'd6: rec_ts[31:0]     <= bus_data_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tsu_q_drain.sv
// Directed bench for tsu_q_drain with a register-bus slave model and op log.
module tb_tsu_q_drain;

  logic         clk = 1'b0;
  logic         rst_n, enable, mask_ld, q_flush, rec_ready, err_clr;
  logic [7:0]   msgid_mask;
  logic         bus_wr_out, bus_rd_out;
  logic [7:0]   bus_addr_out;
  logic [31:0]  bus_data_out;
  logic [31:0]  bus_data_in = '0;
  logic         rec_valid, busy, timeout_err;
  logic [127:0] rec_data;
  logic [79:0]  rec_ts;
  logic [7:0]   rec_level;

  tsu_q_drain #(
    .CTRL_ADDR(8'h40), .STAT_ADDR(8'h44), .DATA_ADDR(8'h50), .TS_ADDR(8'h80),
    .POLL_MAX(16), .IDLE_GAP(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .msgid_mask(msgid_mask),
    .mask_ld(mask_ld), .q_flush(q_flush), .bus_wr_out(bus_wr_out),
    .bus_rd_out(bus_rd_out), .bus_addr_out(bus_addr_out), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .rec_ts(rec_ts), .rec_level(rec_level), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stat_count = 0;
  int ok_after = 0;
  int polls = 0;
  logic both_seen = 1'b0;

  logic        op_k[$];
  logic [7:0]  op_a[$];
  logic [31:0] op_d[$];
  int          op_c[$];

  // Slave model and bus-op log (kind 0 = write, 1 = read).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_wr_out && bus_rd_out) both_seen <= 1'b1;
    if (bus_wr_out) begin
      op_k.push_back(1'b0); op_a.push_back(bus_addr_out);
      op_d.push_back(bus_data_out); op_c.push_back(cyc);
      if (bus_addr_out == 8'h40 && bus_data_out[0]) polls <= 0;
    end
    if (bus_rd_out) begin
      op_k.push_back(1'b1); op_a.push_back(bus_addr_out);
      op_d.push_back(32'h0); op_c.push_back(cyc);
      case (bus_addr_out)
        8'h40: begin
          bus_data_in <= ((ok_after != 0) && (polls + 1 >= ok_after)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
          polls <= polls + 1;
        end
        8'h44: bus_data_in <= 32'h5A00_0000 | {24'h0, stat_count[7:0]};
        8'h50: bus_data_in <= 32'h1111_1111;
        8'h54: bus_data_in <= 32'h2222_2222;
        8'h58: bus_data_in <= 32'h3333_3333;
        8'h5C: bus_data_in <= 32'h4444_4444;
        8'h80: bus_data_in <= 32'hDEAD_ABCD;
        8'h84: bus_data_in <= 32'h0000_0005;
        8'h88: bus_data_in <= 32'h1234_5600;
        default: bus_data_in <= 32'hDEAD_BEEF;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_log();
    op_k.delete(); op_a.delete(); op_d.delete(); op_c.delete();
  endtask

  function automatic int n_ops(input logic k, input logic [7:0] a);
    int n = 0;
    for (int i = 0; i < op_k.size(); i++)
      if (op_k[i] == k && op_a[i] == a) n++;
    return n;
  endfunction

  localparam logic [127:0] EXP_DATA = 128'h11111111_22222222_33333333_44444444;
  localparam logic [79:0]  EXP_TS   = 80'hABCD_00000005_12345600;

  initial begin
    logic [215:0] snap;
    logic [55:0]  fa;
    logic         stable;
    int           n;
    logic [67:0]  seq;

    rst_n = 1'b0; enable = 1'b0; msgid_mask = 8'hA5; mask_ld = 1'b0;
    q_flush = 1'b0; rec_ready = 1'b0; err_clr = 1'b0;

    // Reset state
    tick(3);
    chk("rst_bus", {bus_wr_out, bus_rd_out, bus_addr_out, bus_data_out}, '0);
    chk("rst_rec", {rec_valid, rec_level, busy, timeout_err, rec_ts}, '0);
    chk("rst_data", rec_data, '0);

    // Empty queue: mask write, then periodic status reads only
    clr_log(); rst_n = 1'b1; enable = 1'b1;
    tick(150);
    chk("t1_first_op", {op_k.size() > 0, op_k[0], op_a[0], op_d[0]}, {1'b1, 1'b0, 8'h44, 32'hA500_0000});
    chk("t1_ctrl_wr", n_ops(1'b0, 8'h40), 0);
    chk("t1_op_count", op_k.size(), 4);
    chk("t1_period", {op_k[1], op_a[1], op_k[2], op_a[2], op_c[2] - op_c[1]}, {1'b1, 8'h44, 1'b1, 8'h44, 32'd66});

    // Two entries, ok on third poll
    stat_count = 2; ok_after = 3; clr_log();
    for (int i = 0; i < 200 && !rec_valid; i++) tick(1);
    chk("t2_valid", rec_valid, 1'b1);
    chk("t2_data", rec_data, EXP_DATA);
    chk("t2_ts", rec_ts, EXP_TS);
    chk("t2_level", rec_level, 8'd2);
    chk("t2_latency", {op_k[0], op_a[0], cyc - op_c[0]}, {1'b1, 8'h44, 32'd24});
    chk("t2_polls", n_ops(1'b1, 8'h40), 3);
    chk("t2_ctrl_req", {op_k[1], op_a[1], op_d[1], op_k[2], op_a[2], op_d[2]},
        {1'b0, 8'h40, 32'h0, 1'b0, 8'h40, 32'h1});
    fa = '0;
    for (int i = 6; i < 13; i++) fa = {fa[47:0], op_a[i]};
    chk("t2_fetch_addr", {op_k.size(), fa}, {32'd13, 56'h50_54_58_5C_80_84_88});

    // Backpressure: held record, silent bus, then release
    stat_count = 0;
    snap = {rec_data, rec_ts, rec_level};
    n = op_k.size();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!(rec_valid === 1'b1 && {rec_data, rec_ts, rec_level} === snap)) stable = 1'b0;
    end
    chk("t3_stable", stable, 1'b1);
    chk("t3_no_strobe", op_k.size(), n);
    rec_ready = 1'b1; tick(1); rec_ready = 1'b0;
    chk("t3_valid_fall", rec_valid, 1'b0);
    tick(2);
    chk("t3_rel_stat", {op_k[n], op_a[n], op_d[n], op_k[n+1], op_a[n+1], op_c[n+1] - op_c[n]},
        {1'b0, 8'h40, 32'h0, 1'b1, 8'h44, 32'd1});
    chk("t3_ctrl_seq", {op_d[1][7:0], op_d[2][7:0], op_d[n][7:0]}, 24'h00_01_00);

    // Poll timeout
    ok_after = 0; stat_count = 1; clr_log();
    for (int i = 0; i < 300 && !timeout_err; i++) tick(1);
    enable = 1'b0;
    chk("t4_to_set", timeout_err, 1'b1);
    tick(3);
    chk("t4_poll_n", n_ops(1'b1, 8'h40), 16);
    chk("t4_ctrl_wr_n", n_ops(1'b0, 8'h40), 3);
    chk("t4_last_wr", {op_k[op_k.size()-1], op_a[op_a.size()-1], op_d[op_d.size()-1]}, {1'b0, 8'h40, 32'h0});
    chk("t4_idle_sticky", {busy, timeout_err}, 2'b01);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4_err_clr", timeout_err, 1'b0);

    // Flush requested mid-fetch: record completes, flush follows
    ok_after = 1; stat_count = 1; enable = 1'b1; clr_log();
    for (int i = 0; i < 300 && !(bus_rd_out && bus_addr_out == 8'h54); i++) tick(1);
    chk("t5_in_fetch", {bus_rd_out, bus_addr_out}, {1'b1, 8'h54});
    q_flush = 1'b1; tick(1); q_flush = 1'b0;
    for (int i = 0; i < 50 && !rec_valid; i++) tick(1);
    chk("t5_rec", {rec_valid, rec_level, rec_data[127:96], rec_data[31:0]}, {1'b1, 8'd1, 32'h1111_1111, 32'h4444_4444});
    stat_count = 0; clr_log();
    rec_ready = 1'b1; tick(1); rec_ready = 1'b0;
    tick(10);
    seq = {op_k[0], op_a[0], op_d[0][7:0], op_k[1], op_a[1], op_d[1][7:0],
           op_k[2], op_a[2], op_d[2][7:0], op_k[3], op_a[3], op_d[3][7:0]};
    chk("t5_flush_seq", {op_k.size(), seq},
        {32'd4, 1'b0, 8'h40, 8'h00, 1'b0, 8'h40, 8'h02, 1'b0, 8'h40, 8'h00, 1'b1, 8'h44, 8'h00});

    // Reset while polling
    ok_after = 0; stat_count = 1; msgid_mask = 8'h3C; clr_log();
    for (int i = 0; i < 300 && !(bus_rd_out && bus_addr_out == 8'h40); i++) tick(1);
    chk("t6_in_poll", {bus_rd_out, bus_addr_out, busy}, {1'b1, 8'h40, 1'b1});
    rst_n = 1'b0; tick(1);
    chk("t6_rst_bus", {bus_wr_out, bus_rd_out, bus_addr_out, bus_data_out}, '0);
    chk("t6_rst_rec", {rec_valid, rec_level, busy, timeout_err, rec_ts}, '0);
    chk("t6_rst_data", rec_data, '0);
    tick(1);
    chk("t6_rst_hold", {bus_wr_out, bus_rd_out}, 2'b00);
    rst_n = 1'b1; enable = 1'b0; clr_log();
    tick(5);
    chk("t6_first_op", {op_k.size(), op_k[0], op_a[0], op_d[0]}, {32'd1, 1'b0, 8'h44, 32'h3C00_0000});

    // Mask reload
    msgid_mask = 8'h77; mask_ld = 1'b1; tick(1); mask_ld = 1'b0;
    tick(4);
    chk("t7_mask_ld", {op_k.size(), op_k[1], op_a[1], op_d[1]}, {32'd2, 1'b0, 8'h44, 32'h7700_0000});

    chk("bus_one_strobe", both_seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
